// File: rtl/ser_demux_param_pkg.sv
// Shared definitions for the serial-to-channel demultiplexer.
// Contents: FSM state encoding, active-low seven-segment glyphs 0..F, and
//           a constant clog2 helper used to size the address field.
package ser_demux_param_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_LEN  = 3'd2,
        ST_DATA = 3'd3,
        ST_PAR  = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
    localparam logic [6:0] SSD_0 = 7'b1000000;
    localparam logic [6:0] SSD_1 = 7'b1111001;
    localparam logic [6:0] SSD_2 = 7'b0100100;
    localparam logic [6:0] SSD_3 = 7'b0110000;
    localparam logic [6:0] SSD_4 = 7'b0011001;
    localparam logic [6:0] SSD_5 = 7'b0010010;
    localparam logic [6:0] SSD_6 = 7'b0000010;
    localparam logic [6:0] SSD_7 = 7'b1111000;
    localparam logic [6:0] SSD_8 = 7'b0000000;
    localparam logic [6:0] SSD_9 = 7'b0010000;
    localparam logic [6:0] SSD_A = 7'b0001000;
    localparam logic [6:0] SSD_B = 7'b0000011;
    localparam logic [6:0] SSD_C = 7'b1000110;
    localparam logic [6:0] SSD_D = 7'b0100001;
    localparam logic [6:0] SSD_E = 7'b0000110;
    localparam logic [6:0] SSD_F = 7'b0001110;

    function automatic int sdp_clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Address field is never narrower than one bit.
    function automatic int sdp_addr_w(input int num_ch);
        return (sdp_clog2(num_ch) < 1) ? 1 : sdp_clog2(num_ch);
    endfunction

endpackage

// File: rtl/ser_demux_param_hex_to_ssd.sv
// Hex nibble to active-low seven-segment decoder.
// Latency: purely combinational, zero cycles.
// Backpressure: none; ports i_hex (4-bit value), o_seg (7-bit {g..a}, active-low).
module hex_to_ssd
    import ser_demux_param_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SSD_0;
        case (i_hex)
            4'h0: o_seg = SSD_0;
            4'h1: o_seg = SSD_1;
            4'h2: o_seg = SSD_2;
            4'h3: o_seg = SSD_3;
            4'h4: o_seg = SSD_4;
            4'h5: o_seg = SSD_5;
            4'h6: o_seg = SSD_6;
            4'h7: o_seg = SSD_7;
            4'h8: o_seg = SSD_8;
            4'h9: o_seg = SSD_9;
            4'hA: o_seg = SSD_A;
            4'hB: o_seg = SSD_B;
            4'hC: o_seg = SSD_C;
            4'hD: o_seg = SSD_D;
            4'hE: o_seg = SSD_E;
            4'hF: o_seg = SSD_F;
            default: o_seg = SSD_0;
        endcase
    end

endmodule

// File: rtl/ser_demux_param.sv
// Framed serial stream demultiplexer: start, address, length, payload, optional parity.
// Latency: payload routing to ch_out is combinational (zero cycles); framing state advances one field bit per enabled cycle.
// Backpressure: none; clk_en=0 freezes all state. Ports: clk/rst/clk_en/ser_in in; ch_out, ch_sel, ser_out_valid, done, addr_err, par_err, ssd_out out.
module ser_demux_param
    import ser_demux_param_pkg::*;
#(
    parameter  int NUM_CH    = 4,
    parameter  int CNT_W     = 4,
    parameter  int PARITY_EN = 0,
    localparam int ADDR_W    = sdp_addr_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic              ser_in,
    output logic [NUM_CH-1:0] ch_out,
    output logic [ADDR_W-1:0] ch_sel,
    output logic              ser_out_valid,
    output logic              done,
    output logic              addr_err,
    output logic              par_err,
    output logic [6:0]        ssd_out
);

    // Address and length fields are at most 4 bits, so a 2-bit index covers both.
    localparam int BC_W = 2;
    localparam logic [ADDR_W:0] NUM_CH_V = (ADDR_W+1)'(NUM_CH);

    state_t            r_state;
    logic [ADDR_W-1:0] r_ch_sel;
    logic [CNT_W-1:0]  r_rem_cnt;
    logic [BC_W-1:0]   r_bit_cnt;
    logic              r_addr_err;
    logic              r_par_err;
    logic              r_par_acc;

    logic [ADDR_W-1:0] w_addr_shift;
    logic [CNT_W-1:0]  w_len_shift;
    logic              w_addr_bad;
    logic              w_addr_ok;
    logic              w_route;
    logic              w_addr_last;
    logic              w_len_last;
    state_t            w_after_payload;
    logic [3:0]        w_nibble;
    logic [NUM_CH-1:0] w_ch_out;

    // MSB-first shift registers: the incoming bit enters at the LSB.
    assign w_addr_shift = (r_ch_sel << 1) | ADDR_W'(ser_in);
    assign w_len_shift  = (r_rem_cnt << 1) | CNT_W'(ser_in);
    assign w_addr_bad   = ({1'b0, w_addr_shift} >= NUM_CH_V);
    assign w_addr_ok    = ({1'b0, r_ch_sel} < NUM_CH_V);
    assign w_addr_last  = (r_bit_cnt == BC_W'(ADDR_W - 1));
    assign w_len_last   = (r_bit_cnt == BC_W'(CNT_W - 1));
    assign w_after_payload = (PARITY_EN != 0) ? ST_PAR : ST_DONE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_ch_sel   <= '0;
            r_rem_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_addr_err <= 1'b0;
            r_par_err  <= 1'b0;
            r_par_acc  <= 1'b0;
        end else if (clk_en) begin
            case (r_state)
                ST_IDLE: begin
                    if (!ser_in) begin
                        r_state    <= ST_ADDR;
                        r_bit_cnt  <= '0;
                        r_addr_err <= 1'b0;
                        r_par_err  <= 1'b0;
                    end
                end
                ST_ADDR: begin
                    r_ch_sel <= w_addr_shift;
                    if (w_addr_last) begin
                        r_bit_cnt  <= '0;
                        r_addr_err <= w_addr_bad;
                        r_state    <= ST_LEN;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + BC_W'(1);
                    end
                end
                ST_LEN: begin
                    r_rem_cnt <= w_len_shift;
                    r_par_acc <= 1'b0;
                    if (w_len_last) begin
                        r_bit_cnt <= '0;
                        // A zero-length frame skips the payload entirely.
                        r_state   <= (w_len_shift == '0) ? w_after_payload : ST_DATA;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + BC_W'(1);
                    end
                end
                ST_DATA: begin
                    r_rem_cnt <= r_rem_cnt - CNT_W'(1);
                    r_par_acc <= r_par_acc ^ ser_in;
                    if (r_rem_cnt == CNT_W'(1)) begin
                        r_state <= w_after_payload;
                    end
                end
                ST_PAR: begin
                    // Even parity: payload XOR parity bit must be zero.
                    r_par_err <= r_par_acc ^ ser_in;
                    r_state   <= ST_DONE;
                end
                ST_DONE: begin
                    // Always return to IDLE; a low line here is not a start bit.
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Routing only while in DATA and only for an address that maps to a channel.
    assign w_route = (r_state == ST_DATA) && w_addr_ok;

    always_comb begin
        w_ch_out = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_ch_out[i] = w_route && (r_ch_sel == ADDR_W'(i)) && ser_in;
        end
    end

    assign w_nibble = ((r_state == ST_IDLE) || (r_state == ST_DONE)) ? 4'd0 : 4'(r_rem_cnt);

    hex_to_ssd u_hex_to_ssd (
        .i_hex (w_nibble),
        .o_seg (ssd_out)
    );

    assign ch_out        = w_ch_out;
    assign ch_sel        = r_ch_sel;
    assign ser_out_valid = w_route;
    assign done          = (r_state == ST_DONE);
    assign addr_err      = r_addr_err;
    assign par_err       = r_par_err;

endmodule

// File: tb/tb_ser_demux_param.sv
// Directed bench for ser_demux_param: three instances (4 ch, 3 ch, 4 ch with parity).
// Latency: checks sampled 1-2 time units after each rising edge.
// Backpressure: none; clk_en driven directly by the stimulus.
module tb_ser_demux_param;
    import ser_demux_param_pkg::*;

    logic clk;
    logic rst;
    logic clk_en;
    logic ser4, ser3, serp;

    logic [3:0] ch_out4;  logic [1:0] ch_sel4;  logic vld4, done4, aerr4, perr4;  logic [6:0] ssd4;
    logic [2:0] ch_out3;  logic [1:0] ch_sel3;  logic vld3, done3, aerr3, perr3;  logic [6:0] ssd3;
    logic [3:0] ch_outp;  logic [1:0] ch_selp;  logic vldp, donep, aerrp, perrp;  logic [6:0] ssdp;

    int n_checks;
    int n_errors;

    ser_demux_param #(.NUM_CH(4), .CNT_W(4), .PARITY_EN(0)) u_dut4 (
        .clk(clk), .rst(rst), .clk_en(clk_en), .ser_in(ser4),
        .ch_out(ch_out4), .ch_sel(ch_sel4), .ser_out_valid(vld4), .done(done4),
        .addr_err(aerr4), .par_err(perr4), .ssd_out(ssd4)
    );

    ser_demux_param #(.NUM_CH(3), .CNT_W(4), .PARITY_EN(0)) u_dut3 (
        .clk(clk), .rst(rst), .clk_en(clk_en), .ser_in(ser3),
        .ch_out(ch_out3), .ch_sel(ch_sel3), .ser_out_valid(vld3), .done(done3),
        .addr_err(aerr3), .par_err(perr3), .ssd_out(ssd3)
    );

    ser_demux_param #(.NUM_CH(4), .CNT_W(4), .PARITY_EN(1)) u_dutp (
        .clk(clk), .rst(rst), .clk_en(clk_en), .ser_in(serp),
        .ch_out(ch_outp), .ch_sel(ch_selp), .ser_out_valid(vldp), .done(donep),
        .addr_err(aerrp), .par_err(perrp), .ssd_out(ssdp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send4(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            ser4 = bits[i];
            tick();
        end
    endtask

    task automatic send4_slow(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            ser4   = bits[i];
            clk_en = 1'b0;
            tick();
            clk_en = 1'b1;
            tick();
        end
    endtask

    task automatic send3(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            ser3 = bits[i];
            tick();
        end
    endtask

    task automatic sendp(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            serp = bits[i];
            tick();
        end
    endtask

    initial begin
        logic [6:0] exp_ssd [3];
        logic [2:0] pay;
        logic       b;

        n_checks = 0;
        n_errors = 0;
        exp_ssd[0] = SSD_3;
        exp_ssd[1] = SSD_2;
        exp_ssd[2] = SSD_1;
        pay = 3'b101;

        rst = 1'b0; clk_en = 1'b1; ser4 = 1'b1; ser3 = 1'b1; serp = 1'b1;
        #2;
        chk("rst_ch_out", 32'(ch_out4), 32'h0);
        chk("rst_ch_sel", 32'(ch_sel4), 32'h0);
        chk("rst_valid",  32'(vld4),    32'h0);
        chk("rst_done",   32'(done4),   32'h0);
        chk("rst_aerr",   32'(aerr4),   32'h0);
        chk("rst_perr",   32'(perr4),   32'h0);
        chk("rst_ssd",    32'(ssd4),    32'(SSD_0));
        tick(); tick();
        rst = 1'b1;
        tick();

        // Frame: start 0, addr 10, len 0011, payload 1,0,1.
        send4(16'b0_10_0011, 7);
        chk("t1_ch_sel", 32'(ch_sel4), 32'h2);
        ser4 = 1'b1; #1;
        chk("t1_b0_ch",  32'(ch_out4), 32'h4);
        chk("t1_b0_vld", 32'(vld4),    32'h1);
        chk("t1_b0_ssd", 32'(ssd4),    32'(SSD_3));
        tick();
        ser4 = 1'b0; #1;
        chk("t1_b1_ch",  32'(ch_out4), 32'h0);
        chk("t1_b1_vld", 32'(vld4),    32'h1);
        chk("t1_b1_ssd", 32'(ssd4),    32'(SSD_2));
        tick();
        ser4 = 1'b1; #1;
        chk("t1_b2_ch",  32'(ch_out4), 32'h4);
        chk("t1_b2_ssd", 32'(ssd4),    32'(SSD_1));
        tick();
        // DONE with the line low: must not be taken as a new start bit.
        ser4 = 1'b0; #1;
        chk("t1_done",     32'(done4),   32'h1);
        chk("t1_done_vld", 32'(vld4),    32'h0);
        chk("t1_done_ch",  32'(ch_out4), 32'h0);
        chk("t1_done_ssd", 32'(ssd4),    32'(SSD_0));
        tick();
        ser4 = 1'b1; #1;
        chk("t1_idle_done", 32'(done4), 32'h0);
        tick();

        // Same frame with clk_en alternating 0/1.
        send4_slow(16'b0_10_0011, 7);
        chk("t2_ch_sel", 32'(ch_sel4), 32'h2);
        for (int i = 0; i < 3; i++) begin
            b = pay[2-i];
            ser4 = b; clk_en = 1'b0; #1;
            chk("t2_pre_ch", 32'(ch_out4), b ? 32'h4 : 32'h0);
            tick();
            chk("t2_hold_ch",  32'(ch_out4), b ? 32'h4 : 32'h0);
            chk("t2_hold_vld", 32'(vld4),    32'h1);
            chk("t2_hold_ssd", 32'(ssd4),    32'(exp_ssd[i]));
            clk_en = 1'b1; #1;
            chk("t2_en_ssd", 32'(ssd4), 32'(exp_ssd[i]));
            tick();
        end
        ser4 = 1'b1; clk_en = 1'b0;
        tick();
        chk("t2_done_hold", 32'(done4), 32'h1);
        clk_en = 1'b1;
        tick();
        chk("t2_done_clr", 32'(done4), 32'h0);

        // Zero-length frame: straight from LEN to DONE.
        send4(16'b0_01_0000, 7);
        chk("t3_done", 32'(done4),   32'h1);
        chk("t3_vld",  32'(vld4),    32'h0);
        chk("t3_ch",   32'(ch_out4), 32'h0);
        ser4 = 1'b1;
        tick();
        chk("t3_idle", 32'(done4), 32'h0);

        // NUM_CH=3, address 11 is out of range.
        send3(16'b0_11_0010, 7);
        chk("t4_aerr", 32'(aerr3), 32'h1);
        ser3 = 1'b1; #1;
        chk("t4_b0_ch",  32'(ch_out3), 32'h0);
        chk("t4_b0_vld", 32'(vld3),    32'h0);
        tick();
        ser3 = 1'b1; #1;
        chk("t4_b1_ch",  32'(ch_out3), 32'h0);
        tick();
        chk("t4_done",      32'(done3), 32'h1);
        chk("t4_aerr_hold", 32'(aerr3), 32'h1);
        ser3 = 1'b1;
        tick();
        ser3 = 1'b0;
        tick();
        chk("t4_aerr_clr", 32'(aerr3), 32'h0);
        send3(16'b01_0000, 6);
        chk("t4_ch_sel", 32'(ch_sel3), 32'h1);
        chk("t4_done2",  32'(done3),   32'h1);
        ser3 = 1'b1;
        tick();

        // Parity: payload 1,1,0 (even) with parity bit 1 -> error.
        sendp(16'b0_01_0011, 7);
        sendp(16'b110, 3);
        chk("t5_par_vld", 32'(vldp), 32'h0);
        serp = 1'b1;
        tick();
        chk("t5_perr1", 32'(perrp), 32'h1);
        chk("t5_done1", 32'(donep), 32'h1);
        serp = 1'b1;
        tick();
        serp = 1'b0;
        tick();
        chk("t5_perr_clr", 32'(perrp), 32'h0);
        sendp(16'b01_0011, 6);
        sendp(16'b110, 3);
        serp = 1'b0;
        tick();
        chk("t5_perr0", 32'(perrp), 32'h0);
        chk("t5_done0", 32'(donep), 32'h1);
        serp = 1'b1;
        tick();
        // Odd payload 1,0,0 with parity bit 1 is correct even parity.
        sendp(16'b0_10_0011, 7);
        sendp(16'b100, 3);
        serp = 1'b1;
        tick();
        chk("t5_perr_odd", 32'(perrp), 32'h0);
        serp = 1'b1;
        tick();

        // Asynchronous reset in the middle of DATA.
        send4(16'b0_01_0011, 7);
        ser4 = 1'b1; #1;
        chk("t6_pre_ch", 32'(ch_out4), 32'h2);
        rst = 1'b0; #1;
        chk("t6_rst_ch",   32'(ch_out4), 32'h0);
        chk("t6_rst_vld",  32'(vld4),    32'h0);
        chk("t6_rst_sel",  32'(ch_sel4), 32'h0);
        chk("t6_rst_done", 32'(done4),   32'h0);
        chk("t6_rst_ssd",  32'(ssd4),    32'(SSD_0));
        tick(); tick();
        rst = 1'b1;
        tick();
        send4(16'b0_01_0010, 7);
        ser4 = 1'b1; #1;
        chk("t6_b0_ch",  32'(ch_out4), 32'h2);
        chk("t6_sel",    32'(ch_sel4), 32'h1);
        chk("t6_b0_ssd", 32'(ssd4),    32'(SSD_2));
        tick();
        ser4 = 1'b0; #1;
        chk("t6_b1_ch",  32'(ch_out4), 32'h0);
        chk("t6_b1_vld", 32'(vld4),    32'h1);
        chk("t6_b1_ssd", 32'(ssd4),    32'(SSD_1));
        tick();
        chk("t6_done", 32'(done4), 32'h1);
        ser4 = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
